// File: rtl/cache_pkg.sv
// Shared field widths, line size and FSM encoding for the direct-mapped data cache.
package cache_pkg;
    localparam int OFFSET_W   = 5;
    localparam int INDEX_W    = 4;
    localparam int TAG_W      = 23;
    localparam int WORD_SEL_W = 3;
    localparam int LINE_BITS  = 256;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WRITEBACK   = 2'd1,
        REFILL      = 2'd2,
        REFILL_DONE = 2'd3
    } state_e;
endpackage

// File: rtl/dcache_sram.sv
// Line storage: async read, sync line/word write, async clear of valid/dirty.
module dcache_sram
    import cache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = cache_pkg::LINE_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_W-1:0]    rd_index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_BITS-1:0]  rd_data,
    input  logic                  line_we,
    input  logic [INDEX_W-1:0]    line_index,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic [LINE_BITS-1:0]  line_data,
    input  logic                  word_we,
    input  logic [INDEX_W-1:0]    word_index,
    input  logic [WORD_SEL_W-1:0] word_sel,
    input  logic [31:0]           word_data
);
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (line_we) begin
                valid_q[line_index] <= 1'b1;
                dirty_q[line_index] <= 1'b0;
            end
            if (word_we)
                dirty_q[word_index] <= 1'b1;
        end
    end

    // Tag/data carry no reset; valid gates every use of them.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_q[line_index]  <= line_tag;
            data_q[line_index] <= line_data;
        end
        if (word_we)
            data_q[word_index][{word_sel, 5'b0} +: 32] <= word_data;
    end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate D-cache controller: hit path, miss FSM, memory handshake.
module dcache_controller
    import cache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = cache_pkg::LINE_BITS,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_write_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);
    state_e                  state_q, state_d;
    logic [TAG_W-1:0]        req_tag_q;
    logic [INDEX_W-1:0]      req_index_q;
    logic                    gap_q;

    logic [TAG_W-1:0]        cpu_tag;
    logic [INDEX_W-1:0]      cpu_index;
    logic [WORD_SEL_W-1:0]   cpu_wsel;
    logic                    unused_addr_lsb;

    logic [INDEX_W-1:0]      rd_index;
    logic                    rd_valid, rd_dirty;
    logic [TAG_W-1:0]        rd_tag;
    logic [LINE_BITS-1:0]    rd_data;
    logic                    hit, miss, line_we, word_we;

    assign cpu_tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign cpu_index       = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign cpu_wsel        = cpu_addr_i[2 +: WORD_SEL_W];
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    // Once a miss is taken the latched index owns the array port, so the
    // victim line stays stable even if the pipeline changes its request.
    assign rd_index    = (state_q == IDLE) ? cpu_index : req_index_q;
    assign hit         = (state_q == IDLE) && rd_valid && (rd_tag == cpu_tag);
    assign miss        = cpu_req_i && !hit;
    assign cpu_stall_o = !rst_i && (miss || (state_q != IDLE));
    assign cpu_data_o  = hit ? rd_data[{cpu_wsel, 5'b0} +: 32] : '0;
    assign word_we     = hit && cpu_req_i && cpu_write_i;

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS)
    ) u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_index   (rd_index),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .line_we    (line_we),
        .line_index (req_index_q),
        .line_tag   (req_tag_q),
        .line_data  (mem_data_i),
        .word_we    (word_we),
        .word_index (cpu_index),
        .word_sel   (cpu_wsel),
        .word_data  (cpu_data_i)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_tag_q   <= '0;
            req_index_q <= '0;
            gap_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && miss) begin
                req_tag_q   <= cpu_tag;
                req_index_q <= cpu_index;
            end
            // One idle bus cycle between the writeback ack and the refill request.
            gap_q <= (state_q == WRITEBACK) && mem_ack_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        line_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss)
                    state_d = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rd_tag, req_index_q, {OFFSET_W{1'b0}}};
                mem_data_o   = rd_data;
                if (mem_ack_i)
                    state_d = REFILL;
            end
            REFILL: begin
                mem_enable_o = !gap_q;
                mem_addr_o   = {req_tag_q, req_index_q, {OFFSET_W{1'b0}}};
                if (!gap_q && mem_ack_i) begin
                    line_we = 1'b1;
                    state_d = REFILL_DONE;
                end
            end
            REFILL_DONE: state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: transaction-level cache model plus per-cycle compare.
module tb_dcache_controller;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_write_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o, mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic         mem_ack_i;

    dcache_controller dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_write_i  (cpu_write_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0, n_total = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Cache model (what the cache must hold) and reference memory contents.
    logic         m_valid [16];
    logic         m_dirty [16];
    logic [22:0]  m_tag   [16];
    logic [255:0] m_data  [16];
    logic [255:0] ref_mem [logic [31:0]];
    // Memory responder's own storage, written only by DUT writebacks.
    logic [255:0] bmem    [logic [31:0]];

    function automatic logic [255:0] init_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = a + 32'(i * 4) + 32'h5000_0000;
        return l;
    endfunction

    function automatic logic [255:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    // Memory responder: acks on the N-th cycle a request has been held.
    int           wdelay = 1, rdelay = 1, mcnt = 0;
    logic         stray_ack = 1'b0;
    logic [31:0]  last_wb_addr = '0, last_wb_word0 = '0;

    always @(negedge clk_i) begin
        if (rst_i || !mem_enable_o) begin
            mcnt      = 0;
            mem_ack_i = stray_ack;
        end else begin
            mcnt++;
            if (mcnt == (mem_write_o ? wdelay : rdelay)) begin
                mem_ack_i = 1'b1;
                mcnt      = 0;
                if (mem_write_o) begin
                    bmem[mem_addr_o] = mem_data_o;
                    last_wb_addr     = mem_addr_o;
                    last_wb_word0    = mem_data_o[31:0];
                end else begin
                    mem_data_i = bmem.exists(mem_addr_o) ? bmem[mem_addr_o] : init_line(mem_addr_o);
                end
            end else begin
                mem_ack_i = 1'b0;
            end
        end
    end

    // Expectations for the access in flight.
    logic         active = 1'b0, done = 1'b0, idle_mon = 1'b0;
    logic         victim, exp_load;
    logic [31:0]  exp_wb_addr, exp_rf_addr, exp_word;
    logic [255:0] exp_wb_data;
    int           exp_len, e_dw, e_dr, cyc, stall_seen;
    logic         c_es, c_wb, c_rf;

    always @(negedge clk_i) begin
        if (active && !done) begin
            c_es = (cyc < exp_len);
            c_wb = victim && cyc >= 1 && cyc <= e_dw;
            c_rf = (exp_len != 0) && (victim ? (cyc >= e_dw + 2 && cyc <= e_dw + e_dr + 1)
                                             : (cyc >= 1 && cyc <= e_dr));
            chk("stall", cpu_stall_o, c_es);
            chk("mem_enable", mem_enable_o, c_wb || c_rf);
            if (c_wb) begin
                chk("wb_write", mem_write_o, 1'b1);
                chk("wb_addr", mem_addr_o, exp_wb_addr);
                chk("wb_data", mem_data_o, exp_wb_data);
            end
            if (c_rf) begin
                chk("rf_write", mem_write_o, 1'b0);
                chk("rf_addr", mem_addr_o, exp_rf_addr);
            end
            if (cpu_stall_o) stall_seen++;
            if (!c_es) begin
                if (exp_load) chk("load_data", cpu_data_o, exp_word);
                done = 1'b1;
            end
            cyc++;
        end else if (!active && idle_mon) begin
            chk("idle_stall", cpu_stall_o, 1'b0);
            chk("idle_enable", mem_enable_o, 1'b0);
        end
    end

    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input int dw, input int dr, input int lit_stall,
                          input bit use_lit, input logic [31:0] lit_data);
        int idx, ws, guard;
        logic [22:0] tg;
        bit hit_m;
        idx   = int'(a[8:5]);
        ws    = int'(a[4:2]);
        tg    = a[31:9];
        hit_m = m_valid[idx] && m_tag[idx] == tg;
        victim      = !hit_m && m_valid[idx] && m_dirty[idx];
        exp_wb_addr = {m_tag[idx], a[8:5], 5'b0};
        exp_wb_data = m_data[idx];
        exp_rf_addr = {a[31:5], 5'b0};
        exp_len     = hit_m ? 0 : (victim ? dw + dr + 3 : dr + 2);
        if (!hit_m) begin
            if (victim) ref_mem[exp_wb_addr] = m_data[idx];
            m_data[idx]  = ref_rd(exp_rf_addr);
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        exp_word = m_data[idx][ws*32 +: 32];
        if (wr) begin
            m_data[idx][ws*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end
        exp_load = !wr;
        wdelay = dw; rdelay = dr; e_dw = dw; e_dr = dr;
        cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = a; cpu_data_i = wd;
        cyc = 0; done = 1'b0; stall_seen = 0; active = 1'b1;
        guard = 0;
        while (!done && guard < exp_len + 40) begin
            @(posedge clk_i); #1;
            guard++;
        end
        if (!done) chk("access_timeout", done, 1'b1);
        chk("stall_cycles", stall_seen, lit_stall);
        if (use_lit && !wr) chk("load_literal", cpu_data_o, lit_data);
        active = 1'b0;
        cpu_req_i = 1'b0; cpu_write_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    initial begin
        logic [255:0] ln;
        int guard;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
        end
        ln = init_line(32'h40);
        ln[31:0]  = 32'h1122_3344;
        ln[63:32] = 32'h5566_7788;
        ref_mem[32'h40] = ln;
        bmem[32'h40]    = ln;

        rst_i = 1'b1; cpu_req_i = 1'b0; cpu_write_i = 1'b0;
        cpu_addr_i = '0; cpu_data_i = '0; mem_data_i = '0; mem_ack_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rst_stall", cpu_stall_o, 1'b0);
        chk("rst_enable", mem_enable_o, 1'b0);
        chk("rst_write", mem_write_o, 1'b0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_mdata", mem_data_o, 256'h0);
        chk("rst_cdata", cpu_data_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; idle_mon = 1'b1;
        @(posedge clk_i); #1;

        // Clean miss, hit, store hit, dirty eviction.
        access(0, 32'h40,  0,            1, 3,  5, 1, 32'h1122_3344);
        access(0, 32'h44,  0,            1, 1,  0, 1, 32'h5566_7788);
        access(1, 32'h40,  32'hDEAD_BEEF, 1, 1,  0, 0, 32'h0);
        access(0, 32'h240, 0,            2, 2,  7, 1, 32'h5000_0240);
        chk("wb_addr_literal",  last_wb_addr,  32'h40);
        chk("wb_word0_literal", last_wb_word0, 32'hDEAD_BEEF);

        // Slow refill, then dirty the line for the reset test.
        access(0, 32'h440, 0,            1, 10, 12, 1, 32'h5000_0440);
        access(1, 32'h444, 32'hCAFE_F00D, 1, 1,  0, 0, 32'h0);

        // Reset while the dirty victim is being written back.
        idle_mon = 1'b0; wdelay = 20; rdelay = 1;
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h40;
        guard = 0;
        while (!(mem_enable_o && mem_write_o) && guard < 10) begin
            @(posedge clk_i); #1;
            guard++;
        end
        chk("rstwb_busy", {mem_enable_o, mem_write_o}, 2'b11);
        chk("rstwb_addr", mem_addr_o, 32'h440);
        @(posedge clk_i); #2;
        rst_i = 1'b1; cpu_req_i = 1'b0;
        #1;
        chk("rstwb_stall", cpu_stall_o, 1'b0);
        chk("rstwb_enable", mem_enable_o, 1'b0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
        idle_mon = 1'b1;
        @(posedge clk_i); #1;
        access(0, 32'h40, 0, 1, 1, 3, 1, 32'hDEAD_BEEF);

        // Same-index thrash: every access a clean miss.
        for (int i = 0; i < 4; i++)
            access(0, (i % 2) ? 32'h200 : 32'h000, 0, 1, 1 + (i % 2),
                   (i % 2) ? 4 : 3, 1, (i % 2) ? 32'h5000_0200 : 32'h5000_0000);

        // Stray ack while idle must be ignored.
        stray_ack = 1'b1;
        @(posedge clk_i); #1;
        stray_ack = 1'b0;
        @(posedge clk_i); #1;
        access(0, 32'h44, 0, 1, 1, 0, 1, 32'h5566_7788);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the MEM stage and the 256-bit data memory.
- Produces the memory-side stall that the pipeline consumes alongside the load-use stall. While `cpu_stall_o` is high, the pipeline freezes PC and all pipeline registers.
- On a hit it serves 32-bit loads and stores with zero added latency. On a miss it runs a writeback/refill handshake with memory.

Parameters:
- NUM_LINES, 16, number of cache lines (power of 2).
- LINE_BITS, 256, line and memory-bus width in bits (32 bytes).
- ADDR_W, 32, CPU byte-address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- cpu_req_i  in  1  MEM-stage access valid (MemRead or MemWrite).
- cpu_write_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address, word-aligned.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data, valid when cpu_req_i=1, cpu_write_i=0, cpu_stall_o=0.
- cpu_stall_o  out  1  1 = freeze pipeline.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = line write, 0 = line read.
- mem_addr_o  out  32  line-aligned address (bits [4:0] = 0).
- mem_data_o  out  256  writeback line.
- mem_data_i  in  256  refill line.
- mem_ack_i  in  1  one-cycle completion pulse from memory.

Behaviour:
- Address split:
  - offset = addr[4:0]; word select = addr[4:2].
  - index = addr[8:5].
  - tag = addr[31:9] (23 bits).
- Per-line storage: valid, dirty, tag[22:0], data[255:0].
- Reset (asynchronous):
  - State = IDLE; all valid and dirty bits = 0.
  - cpu_stall_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, cpu_data_o=0.
  - Data and tag arrays need not be reset.
- hit = valid[index] && tag[index]==addr tag. miss = cpu_req_i && !hit.
- cpu_stall_o = miss || (state != IDLE). It is combinational, so it rises in the same cycle as the missing request.
- Read hit: cpu_data_o = selected word, combinational, same cycle.
- Write hit: at the clock edge, the word is replaced and dirty[index]=1.
- cpu_req_i=0: no array change, no stall (in IDLE).
- FSM states: IDLE, WRITEBACK, REFILL, REFILL_DONE.
  - IDLE: on miss, go to WRITEBACK if valid&&dirty of the victim; otherwise go to REFILL.
  - WRITEBACK:
    - Drive mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line.
    - Hold all of these stable until mem_ack_i=1, then go to REFILL.
  - REFILL:
    - Drive mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}.
    - On mem_ack_i=1: line=mem_data_i, tag=req tag, valid=1, dirty=0; go to REFILL_DONE.
  - REFILL_DONE: mem_enable_o=0, stall held. Next cycle go to IDLE, where the held request now hits and completes (a store sets dirty then).
- mem_enable_o drops for at least one cycle between WRITEBACK ack and the REFILL request. Memory handshake rule: a request stays asserted until acked and is never withdrawn.
- mem_ack_i outside WRITEBACK or REFILL is ignored.
- Latency:
  - Clean miss = refill memory latency + 2 cycles of stall.
  - Dirty miss = writeback latency + refill latency + 3 cycles.
- cpu_req_i dropping mid-miss (e.g. reset of the pipeline not coinciding): the current refill completes and the line is installed; no abort.
- Same-index different-tag accesses thrash correctly: each access evicts per the rules above.
- rst_i mid-transaction: immediately return to IDLE and clear all valid bits; the outstanding memory request is abandoned. The memory model must tolerate a dropped mem_enable_o.

Decomposition:
- Shared package `cache_pkg`:
  - Field widths (OFFSET_W=5, INDEX_W=4, TAG_W=23, WORD_SEL_W=3).
  - FSM state encoding (2-bit).
  - LINE_BITS constant.
- One sub-module, `dcache_sram`:
  - NUM_LINES-entry array of {valid, dirty, tag, data}.
  - Asynchronous read; synchronous write with a line-write port and a word-write port.
  - Asynchronous valid/dirty clear on rst_i.
- The controller holds the FSM, hit logic and word mux.

Test Plan:
- Reset, then load 0x00000040 with memory line = 256'h…11223344 at word 0 → cpu_stall_o=1 same cycle; REFILL with mem_addr_o=0x40; after ack+2 cycles cpu_stall_o=0 and cpu_data_o=0x11223344.
- Repeat load 0x00000044 right after → hit: cpu_stall_o=0, mem_enable_o never asserts, data = word 1 of that line.
- Store 0xDEADBEEF to 0x40 (hit), then load 0x00000240 (same index 2, tag 1) → WRITEBACK to 0x40 with word0=0xDEADBEEF, then REFILL at 0x240, then the load completes.
- Memory ack delayed 10 cycles in REFILL → mem_enable_o and mem_addr_o stable for all 10 cycles and cpu_stall_o stays high; exactly one line install.
- Assert rst_i during WRITEBACK → same-cycle return to IDLE with cpu_stall_o=0 and mem_enable_o=0; a subsequent load to 0x40 misses (valid cleared).
- Alternating loads to 0x000 and 0x200 (same index) → every access misses clean, no writebacks, correct data each time.
